// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Purpose : Paired-instruction fetch front end; issues one ICache request at a
//           time, pushes returned pairs to the instruction buffer and follows
//           branch predictions, including a taken branch in the second slot.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc_i,
    input  logic        buffer_full_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_addr_ok_i,
    input  logic        icache_data_ok_i,
    input  logic [31:0] icache_rdata1_i,
    input  logic [31:0] icache_rdata2_i,
    input  logic        bpu_taken_i,
    input  logic        bpu_slot_i,
    input  logic [31:0] bpu_target_i,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] inst1_addr_o,
    output logic [31:0] inst2_addr_o,
    output logic        inst1_valid_o,
    output logic        inst2_valid_o,
    output logic        only_delayslot_inst_o,
    output logic [32:0] bpu_predict_info_o,
    output logic        bpu_select_o
);

    localparam logic [1:0]  c_ST_REQ   = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_DROP  = 2'd2;
    localparam logic [31:0] c_RESET_PC = 32'hBFC0_0000;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_ds_pending;
    logic [31:0] r_ds_target;

    logic        w_push;
    logic        w_pred_taken;

    // Pushes are combinational on data_ok so a response reaches the buffer
    // in the cycle it returns; reset and flush both suppress it.
    assign w_push       = (r_state == c_ST_WAIT) & icache_data_ok_i & ~flush & ~rst;
    assign w_pred_taken = w_push & ~r_ds_pending & bpu_taken_i;

    assign icache_req_o  = (r_state == c_ST_REQ) & ~buffer_full_i & ~flush;
    assign icache_addr_o = r_pc;

    assign inst1_o               = icache_rdata1_i;
    assign inst2_o               = icache_rdata2_i;
    assign inst1_addr_o          = r_pc;
    assign inst2_addr_o          = r_pc + 32'd4;
    assign inst1_valid_o         = w_push;
    assign inst2_valid_o         = w_push & ~r_ds_pending;
    assign only_delayslot_inst_o = w_push & r_ds_pending;
    assign bpu_predict_info_o    = w_pred_taken ? {1'b1, bpu_target_i} : 33'd0;
    assign bpu_select_o          = w_pred_taken & bpu_slot_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_REQ;
            r_pc         <= c_RESET_PC;
            r_ds_pending <= 1'b0;
            r_ds_target  <= 32'd0;
        end else if (flush) begin
            r_pc         <= flush_pc_i;
            r_ds_pending <= 1'b0;
            // A flushed request still owes a response; swallow it in DROP.
            if ((r_state != c_ST_REQ) && !icache_data_ok_i) begin
                r_state <= c_ST_DROP;
            end else begin
                r_state <= c_ST_REQ;
            end
        end else begin
            case (r_state)
                c_ST_REQ: begin
                    if (icache_req_o && icache_addr_ok_i) begin
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (icache_data_ok_i) begin
                        r_state <= c_ST_REQ;
                        if (r_ds_pending) begin
                            r_pc         <= r_ds_target;
                            r_ds_pending <= 1'b0;
                        end else if (bpu_taken_i && !bpu_slot_i) begin
                            r_pc <= bpu_target_i;
                        end else begin
                            // Slot-1 branch: fetch the delay slot pair first.
                            r_pc <= r_pc + 32'd8;
                            if (bpu_taken_i) begin
                                r_ds_pending <= 1'b1;
                                r_ds_target  <= bpu_target_i;
                            end
                        end
                    end
                end
                c_ST_DROP: begin
                    if (icache_data_ok_i) begin
                        r_state <= c_ST_REQ;
                    end
                end
                default: r_state <= c_ST_REQ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Self-checking bench for fetch_unit: directed scenarios plus a
//           randomized ICache/BPU environment compared against a request-level
//           model every cycle.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, flush, buffer_full_i;
    logic [31:0] flush_pc_i;
    logic        icache_req_o;
    logic [31:0] icache_addr_o;
    logic        icache_addr_ok_i, icache_data_ok_i;
    logic [31:0] icache_rdata1_i, icache_rdata2_i;
    logic        bpu_taken_i, bpu_slot_i;
    logic [31:0] bpu_target_i;
    logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
    logic        inst1_valid_o, inst2_valid_o, only_delayslot_inst_o;
    logic [32:0] bpu_predict_info_o;
    logic        bpu_select_o;

    fetch_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc_i(flush_pc_i),
        .buffer_full_i(buffer_full_i),
        .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
        .icache_addr_ok_i(icache_addr_ok_i), .icache_data_ok_i(icache_data_ok_i),
        .icache_rdata1_i(icache_rdata1_i), .icache_rdata2_i(icache_rdata2_i),
        .bpu_taken_i(bpu_taken_i), .bpu_slot_i(bpu_slot_i), .bpu_target_i(bpu_target_i),
        .inst1_o(inst1_o), .inst2_o(inst2_o),
        .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
        .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o),
        .only_delayslot_inst_o(only_delayslot_inst_o),
        .bpu_predict_info_o(bpu_predict_info_o), .bpu_select_o(bpu_select_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: fetch address, pending delay-slot redirect, and the fate of the
    // single outstanding request (0 none, 1 to be pushed, 2 to be discarded).
    logic [31:0] m_pc;
    logic        m_ds;
    logic [31:0] m_dst;
    int          m_out;
    logic        e_acc;

    logic        s_req, s_v1, s_v2, s_only, s_sel;
    logic [31:0] s_addr, s_a1, s_a2;
    logic [32:0] s_info;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [31:0] fpc,
                        input logic b, input logic aok, input logic dok,
                        input logic tk, input logic sl, input logic [31:0] tg);
        logic [31:0] d1, d2;
        logic        e_req, e_push;
        logic [32:0] e_info;
        d1 = $urandom;
        d2 = $urandom;
        @(negedge clk);
        rst = r; flush = f; flush_pc_i = fpc; buffer_full_i = b;
        icache_addr_ok_i = aok; icache_data_ok_i = dok;
        icache_rdata1_i = d1; icache_rdata2_i = d2;
        bpu_taken_i = tk; bpu_slot_i = sl; bpu_target_i = tg;
        #1;
        s_req = icache_req_o; s_addr = icache_addr_o;
        s_v1 = inst1_valid_o; s_v2 = inst2_valid_o; s_only = only_delayslot_inst_o;
        s_info = bpu_predict_info_o; s_sel = bpu_select_o;
        s_a1 = inst1_addr_o; s_a2 = inst2_addr_o;

        e_req  = (m_out == 0) && !b && !f;
        e_push = !r && (m_out == 1) && dok && !f;
        e_info = (e_push && !m_ds && tk) ? {1'b1, tg} : 33'd0;
        if (!r) begin
            chk("req", s_req, e_req);
            if (e_req) chk("req_addr", s_addr, m_pc);
        end
        chk("inst1_valid", s_v1, e_push);
        chk("inst2_valid", s_v2, e_push && !m_ds);
        chk("only_ds", s_only, e_push && m_ds);
        chk("pred_info", s_info, e_info);
        chk("pred_sel", s_sel, e_push && !m_ds && tk && sl);
        if (e_push) begin
            chk("inst1", inst1_o, d1);
            chk("inst2", inst2_o, d2);
            chk("inst1_addr", s_a1, m_pc);
            chk("inst2_addr", s_a2, m_pc + 32'd4);
        end

        e_acc = !r && e_req && aok;
        if (r) begin
            m_pc = 32'hBFC0_0000; m_ds = 1'b0; m_dst = 32'd0; m_out = 0;
        end else if (f) begin
            m_pc  = fpc;
            m_ds  = 1'b0;
            m_out = (m_out != 0 && !dok) ? 2 : 0;
        end else if (m_out == 0) begin
            if (e_acc) m_out = 1;
        end else if (dok) begin
            if (m_out == 1) begin
                if (m_ds) begin
                    m_pc = m_dst; m_ds = 1'b0;
                end else if (tk && !sl) begin
                    m_pc = tg;
                end else begin
                    m_pc = m_pc + 32'd8;
                    if (tk) begin m_ds = 1'b1; m_dst = tg; end
                end
            end
            m_out = 0;
        end
    endtask

    task automatic idle_aok();  step(0, 0, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic data(input logic tk, input logic sl, input logic [31:0] tg);
        step(0, 0, 0, 0, 0, 1, tk, sl, tg);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int ic_busy = 0;
    int ic_cnt  = 0;

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc_i = '0; buffer_full_i = 1'b0;
        icache_addr_ok_i = 1'b0; icache_data_ok_i = 1'b0;
        icache_rdata1_i = '0; icache_rdata2_i = '0;
        bpu_taken_i = 1'b0; bpu_slot_i = 1'b0; bpu_target_i = '0;
        m_pc = 32'hBFC0_0000; m_ds = 1'b0; m_dst = '0; m_out = 0; e_acc = 1'b0;
        @(posedge clk);
        do_reset();
        chk("rst_info", s_info, 33'd0);

        // Sequential fetch
        idle_aok();           chk("seq_req0", {s_req, s_addr}, {1'b1, 32'hBFC0_0000});
        data(0, 0, 0);        chk("seq_push0", {s_v1, s_v2, s_a1, s_a2}, {2'b11, 32'hBFC0_0000, 32'hBFC0_0004});
        idle_aok();           chk("seq_req1", s_addr, 32'hBFC0_0008);
        data(0, 0, 0);
        idle_aok();           chk("seq_req2", s_addr, 32'hBFC0_0010);
        data(0, 0, 0);

        // Taken in slot 0
        do_reset();
        idle_aok();
        data(1, 0, 32'h8000_1000);
        chk("t0_info", {s_v2, s_info, s_sel}, {1'b1, 33'h1_8000_1000, 1'b0});
        idle_aok();           chk("t0_next", s_addr, 32'h8000_1000);
        data(0, 0, 0);

        // Taken in slot 1, delay slot pair fetched next
        do_reset();
        idle_aok();
        data(1, 1, 32'h8000_2000);
        chk("t1_info", {s_v2, s_info, s_sel}, {1'b1, 33'h1_8000_2000, 1'b1});
        idle_aok();           chk("t1_ds_req", s_addr, 32'hBFC0_0008);
        data(1, 0, 32'h1234_5678);
        chk("t1_ds_push", {s_v1, s_v2, s_only, s_info}, {3'b101, 33'd0});
        idle_aok();           chk("t1_tgt_req", s_addr, 32'h8000_2000);
        data(0, 0, 0);

        // Flush while waiting
        do_reset();
        idle_aok();
        step(0, 1, 32'h8000_0180, 0, 0, 0, 0, 0, 0);
        chk("fw_req_off", s_req, 1'b0);
        data(0, 0, 0);        chk("fw_drop", s_v1, 1'b0);
        idle_aok();           chk("fw_next", s_addr, 32'h8000_0180);
        data(0, 0, 0);

        // Buffer full gates requests only
        do_reset();
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);  chk("bf_req0", s_req, 1'b0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);  chk("bf_req1", s_req, 1'b0);
        idle_aok();                       chk("bf_resume", s_req, 1'b1);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0);  chk("bf_inflight", s_v1, 1'b1);
        idle_aok();                       chk("bf_next", s_addr, 32'hBFC0_0008);
        data(0, 0, 0);

        // Flush with data_ok while a delay slot is pending
        do_reset();
        idle_aok();
        data(1, 1, 32'h8000_3000);
        idle_aok();
        step(0, 1, 32'h8000_0400, 0, 0, 1, 0, 0, 0);
        chk("fds_nopush", {s_v1, s_only}, 2'b00);
        idle_aok();           chk("fds_req", s_addr, 32'h8000_0400);
        data(0, 0, 0);
        idle_aok();           chk("fds_seq", s_addr, 32'h8000_0408);
        data(0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic r, f, b, aok, dok;
            logic [31:0] fpc;
            r   = ($urandom_range(0, 99) == 0);
            f   = ($urandom_range(0, 14) == 0);
            fpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'h3);
            b   = ($urandom_range(0, 3) == 0);
            aok = (ic_busy == 0) && !r && ($urandom_range(0, 1) == 1);
            dok = (ic_busy != 0) && (ic_cnt == 0);
            step(r, f, fpc, b, aok, dok, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom & ~32'h3);
            if (dok) ic_busy = 0;
            else if (ic_busy != 0) ic_cnt--;
            if (e_acc) begin
                ic_busy = 1;
                ic_cnt  = $urandom_range(0, 2);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
